// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Drives a single DSP slice (A2/B2 -> M -> P pipeline) as a length-N
// multiply-accumulate engine. A command supplies N, then N operand pairs
// stream in over valid/ready, and the 48-bit sum is returned over a
// valid/ready result port.
//
// Control for the slice travels down a small tag pipeline alongside the
// operand data so that CEP/OPMODE line up with the product sitting in M.
//
// Optional build macro: DSP_MAC_ABORT_EN adds an 'abort' input that cancels
// a command in RUN or DRAIN, pulses dsp_RSTP and returns to IDLE without
// emitting a result.
module dsp_mac_sequencer #(
    parameter int LATENCY = 3,
    parameter int LEN_W   = 8
) (
    input  logic              clk,
    input  logic              RST,
`ifdef DSP_MAC_ABORT_EN
    input  logic              abort,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [29:0]       op_a,
    input  logic [17:0]       op_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [47:0]       res_data,
    output logic [29:0]       dsp_A,
    output logic [17:0]       dsp_B,
    output logic              dsp_CEA2,
    output logic              dsp_CEB2,
    output logic              dsp_CEM,
    output logic              dsp_CEP,
    output logic              dsp_RSTP,
    output logic [6:0]        dsp_OPMODE,
    output logic [3:0]        dsp_ALUMODE,
    output logic [4:0]        dsp_INMODE,
    input  logic [47:0]       dsp_P
);

    // Number of tag stages between the operand fire and the M register.
    localparam int TAGS = LATENCY - 1;

    localparam logic [6:0] OPMODE_LOAD = 7'b0000101;  // P = M
    localparam logic [6:0] OPMODE_ACC  = 7'b0100101;  // P = P + M

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_op_ready;
    logic                r_res_valid;
    logic [47:0]         r_res_data;
    logic [LEN_W-1:0]    r_remain;
    logic                r_first;
    logic                r_last_p;
    logic                r_rstp_pulse;
    logic [TAGS-1:0]     r_tag_v;
    logic [TAGS-1:0]     r_tag_f;
    logic [TAGS-1:0]     r_tag_l;

    logic                w_cmd_fire;
    logic                w_op_fire;
    logic                w_res_fire;
    logic                w_last_beat;
    logic                w_abort;

    assign w_cmd_fire  = cmd_valid & r_cmd_ready;
    assign w_op_fire   = op_valid & r_op_ready;
    assign w_res_fire  = r_res_valid & res_ready;
    assign w_last_beat = (r_remain == LEN_W'(1));

`ifdef DSP_MAC_ABORT_EN
    assign w_abort = abort & ((r_state == S_RUN) | (r_state == S_DRAIN));
`else
    assign w_abort = 1'b0;
`endif

    // Operands go straight to the slice; A2/B2 inside the slice register them.
    assign dsp_A       = op_a;
    assign dsp_B       = op_b;
    assign dsp_CEA2    = 1'b1;
    assign dsp_CEB2    = 1'b1;
    assign dsp_CEM     = 1'b1;
    assign dsp_ALUMODE = 4'b0000;
    assign dsp_INMODE  = 5'b00000;

    // The oldest tag sits beside the product in M and decides the P update.
    assign dsp_CEP    = r_tag_v[TAGS-1];
    assign dsp_OPMODE = (r_tag_v[TAGS-1] & r_tag_f[TAGS-1]) ? OPMODE_LOAD : OPMODE_ACC;
    assign dsp_RSTP   = RST | r_rstp_pulse;

    assign cmd_ready = r_cmd_ready;
    assign op_ready  = r_op_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

    // Tag pipeline: one {valid, first, last} entry per operand beat, shifted every cycle.
    always_ff @(posedge clk) begin
        if (RST || w_abort) begin
            r_tag_v  <= '0;
            r_tag_f  <= '0;
            r_tag_l  <= '0;
            r_last_p <= 1'b0;
        end else begin
            for (int i = TAGS - 1; i > 0; i--) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_f[i] <= r_tag_f[i-1];
                r_tag_l[i] <= r_tag_l[i-1];
            end
            r_tag_v[0] <= w_op_fire;
            r_tag_f[0] <= w_op_fire & r_first;
            r_tag_l[0] <= w_op_fire & w_last_beat;
            // Set on the edge that writes P for the final beat; P is readable next cycle.
            r_last_p   <= r_tag_v[TAGS-1] & r_tag_l[TAGS-1];
        end
    end

    // Command FSM with registered handshakes and result capture.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b1;
            r_op_ready   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= 48'd0;
            r_remain     <= '0;
            r_first      <= 1'b0;
            r_rstp_pulse <= 1'b0;
        end else begin
            r_rstp_pulse <= w_abort;
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_cmd_ready <= 1'b1;
                r_op_ready  <= 1'b0;
                r_remain    <= '0;
                r_first     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cmd_fire) begin
                            r_cmd_ready <= 1'b0;
                            if (cmd_len == '0) begin
                                // Empty dot product: answer immediately with zero.
                                r_state     <= S_DONE;
                                r_res_valid <= 1'b1;
                                r_res_data  <= 48'd0;
                            end else begin
                                r_state    <= S_RUN;
                                r_op_ready <= 1'b1;
                                r_remain   <= cmd_len;
                                r_first    <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_op_fire) begin
                            r_remain <= r_remain - LEN_W'(1);
                            r_first  <= 1'b0;
                            if (w_last_beat) begin
                                r_state    <= S_DRAIN;
                                r_op_ready <= 1'b0;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (r_last_p) begin
                            r_state     <= S_DONE;
                            r_res_valid <= 1'b1;
                            r_res_data  <= dsp_P;
                        end
                    end
                    S_DONE: begin
                        if (w_res_fire) begin
                            r_state     <= S_IDLE;
                            r_res_valid <= 1'b0;
                            r_cmd_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_cmd_ready <= 1'b1;
                        r_op_ready  <= 1'b0;
                        r_res_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP slice closes the loop on
// dsp_P; results are compared against table constants and against a plain
// arithmetic dot-product model for randomized commands.
module tb_dsp_mac_sequencer;

    localparam int LATENCY = 3;
    localparam int LEN_W   = 8;

    logic              clk = 1'b0;
    logic              RST;
`ifdef DSP_MAC_ABORT_EN
    logic              abort;
`endif
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              op_valid;
    logic              op_ready;
    logic [29:0]       op_a;
    logic [17:0]       op_b;
    logic              res_valid;
    logic              res_ready;
    logic [47:0]       res_data;
    logic [29:0]       dsp_A;
    logic [17:0]       dsp_B;
    logic              dsp_CEA2, dsp_CEB2, dsp_CEM, dsp_CEP, dsp_RSTP;
    logic [6:0]        dsp_OPMODE;
    logic [3:0]        dsp_ALUMODE;
    logic [4:0]        dsp_INMODE;
    logic [47:0]       dsp_P;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.LATENCY(LATENCY), .LEN_W(LEN_W)) dut (
        .clk(clk), .RST(RST),
`ifdef DSP_MAC_ABORT_EN
        .abort(abort),
`endif
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_CEA2(dsp_CEA2), .dsp_CEB2(dsp_CEB2),
        .dsp_CEM(dsp_CEM), .dsp_CEP(dsp_CEP), .dsp_RSTP(dsp_RSTP),
        .dsp_OPMODE(dsp_OPMODE), .dsp_ALUMODE(dsp_ALUMODE), .dsp_INMODE(dsp_INMODE),
        .dsp_P(dsp_P)
    );

    // Behavioural DSP slice: A2/B2 -> M -> P, RSTP has priority over CEP.
    logic [29:0] s_a2;
    logic [17:0] s_b2;
    logic [47:0] s_m;
    logic [47:0] s_p;
    always @(posedge clk) begin
        if (dsp_CEA2) s_a2 <= dsp_A;
        if (dsp_CEB2) s_b2 <= dsp_B;
        if (dsp_CEM)
            s_m <= $signed({{23{s_a2[24]}}, s_a2[24:0]}) * $signed({{30{s_b2[17]}}, s_b2});
        if (dsp_RSTP) s_p <= 48'd0;
        else if (dsp_CEP) s_p <= (dsp_OPMODE == 7'b0000101) ? s_m : s_p + s_m;
    end
    assign dsp_P = s_p;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor of slice controls during a command.
    logic mon_en = 1'b0;
    int cep_cnt, first_cnt, run_len, max_run, bad_ctl, bad_const;
    initial begin bad_ctl = 0; bad_const = 0; end
    always @(negedge clk) begin
        if (dsp_ALUMODE !== 4'b0000 || dsp_INMODE !== 5'b00000 || dsp_CEA2 !== 1'b1 ||
            dsp_CEB2 !== 1'b1 || dsp_CEM !== 1'b1 || dsp_A !== op_a || dsp_B !== op_b)
            bad_const++;
        if (mon_en) begin
            if (dsp_CEP === 1'b1) begin
                cep_cnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (dsp_OPMODE == 7'b0000101) first_cnt++;
                else if (dsp_OPMODE != 7'b0100101) bad_ctl++;
            end else begin
                run_len = 0;
            end
        end
    end

    logic [29:0] va [0:15];
    logic [17:0] vb [0:15];

    // Reference dot product: sign-extended A[24:0] times B, wrapped to 48 bits.
    function automatic logic [47:0] ref_sum(input int len);
        longint s = 0;
        for (int i = 0; i < len; i++)
            s += longint'($signed(va[i][24:0])) * longint'($signed(vb[i]));
        return s[47:0];
    endfunction

    // Issue one command with operand gaps and result backpressure; returns result and latency.
    task automatic run_cmd(input int len, input int gap, input int rdelay,
                           output logic [47:0] res, output int lat);
        int guard;
        int fire_cyc;
        int stall_bad;
        logic rdy;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
        cep_cnt = 0; first_cnt = 0; run_len = 0; max_run = 0; mon_en = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        fire_cyc  = cyc;
        for (int i = 0; i < len; i++) begin
            if (i > 0) repeat (gap) begin @(posedge clk); #1; end
            op_valid = 1'b1; op_a = va[i]; op_b = vb[i];
            guard = 0;
            do begin
                @(negedge clk); rdy = op_ready;
                @(posedge clk); #1; guard++;
            end while (!rdy && guard < 50);
            op_valid = 1'b0;
            fire_cyc = cyc;
        end
        guard = 0;
        forever begin
            @(negedge clk);
            if (res_valid === 1'b1) break;
            guard++;
            if (guard > 100) begin
                check("res_valid_timeout", 64'(guard), 64'd0);
                break;
            end
        end
        lat = cyc - fire_cyc;
        res = res_data;
        stall_bad = 0;
        for (int i = 0; i < rdelay; i++) begin
            @(negedge clk);
            if (res_data !== res || res_valid !== 1'b1 || cmd_ready !== 1'b0 || op_ready !== 1'b0)
                stall_bad++;
        end
        if (rdelay > 0) check("stall_stable", 64'(stall_bad), 64'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        mon_en = 1'b0;
        check("idle_after_res", {62'd0, cmd_ready, res_valid}, 64'd2);
    endtask

    typedef struct {
        int               len;
        int               gap;
        logic [3:0][29:0] a;
        logic [3:0][17:0] b;
        logic [47:0]      exp;
        int               exp_run;
    } vec_t;

    vec_t        tbl [0:4];
    logic [47:0] res;
    int          lat;
    int          seen;
    int          rlen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed vectors.
        tbl[0].len = 4; tbl[0].gap = 0; tbl[0].exp = 48'd70; tbl[0].exp_run = 4;
        tbl[0].a = {30'd4, 30'd3, 30'd2, 30'd1}; tbl[0].b = {18'd8, 18'd7, 18'd6, 18'd5};
        tbl[1] = tbl[0]; tbl[1].gap = 2; tbl[1].exp_run = 1;
        tbl[2].len = 1; tbl[2].gap = 0; tbl[2].exp = 48'hFFFF_FFFF_FFEB; tbl[2].exp_run = 1;
        tbl[2].a = {30'd0, 30'd0, 30'd0, 30'h3FFF_FFFD}; tbl[2].b = {18'd0, 18'd0, 18'd0, 18'd7};
        tbl[3].len = 2; tbl[3].gap = 0; tbl[3].exp = 48'd13; tbl[3].exp_run = 2;
        tbl[3].a = {30'd0, 30'd0, 30'd3, 30'd2}; tbl[3].b = {18'd0, 18'd0, 18'd3, 18'd2};
        tbl[4].len = 0; tbl[4].gap = 0; tbl[4].exp = 48'd0; tbl[4].exp_run = 0;
        tbl[4].a = '0; tbl[4].b = '0;

        RST = 1'b1; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
        op_a = '0; op_b = '0; res_ready = 1'b0;
`ifdef DSP_MAC_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rstp", {63'd0, dsp_RSTP}, 64'd1);
        check("rst_ready", {62'd0, cmd_ready, op_ready}, 64'd2);
        check("rst_res", {15'd0, res_valid, res_data}, 64'd0);
        check("rst_cep", {63'd0, dsp_CEP}, 64'd0);
        @(posedge clk); #1;
        RST = 1'b0;
        @(negedge clk);
        check("rstp_release", {63'd0, dsp_RSTP}, 64'd0);
        @(posedge clk); #1;

        // Table-driven directed commands, back-to-back.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) begin va[i] = tbl[v].a[i]; vb[i] = tbl[v].b[i]; end
            run_cmd(tbl[v].len, tbl[v].gap, 0, res, lat);
            check($sformatf("tbl%0d_sum", v), 64'(res), 64'(tbl[v].exp));
            check($sformatf("tbl%0d_lat", v), 64'(lat), (tbl[v].len > 0) ? 64'(LATENCY) : 64'd0);
            check($sformatf("tbl%0d_cep", v), 64'(cep_cnt), 64'(tbl[v].len));
            check($sformatf("tbl%0d_run", v), 64'(max_run), 64'(tbl[v].exp_run));
            check($sformatf("tbl%0d_first", v), 64'(first_cnt), (tbl[v].len > 0) ? 64'd1 : 64'd0);
        end

        // Result held back for 10 cycles.
        for (int i = 0; i < 4; i++) begin va[i] = tbl[0].a[i]; vb[i] = tbl[0].b[i]; end
        run_cmd(4, 0, 10, res, lat);
        check("stall_sum", 64'(res), 64'd70);

        // Randomized commands against the arithmetic model.
        for (int t = 0; t < 20; t++) begin
            rlen = $urandom_range(1, 12);
            for (int i = 0; i < rlen; i++) begin va[i] = 30'($urandom); vb[i] = 18'($urandom); end
            run_cmd(rlen, $urandom_range(0, 2), $urandom_range(0, 3), res, lat);
            check($sformatf("rnd%0d_sum", t), 64'(res), 64'(ref_sum(rlen)));
            check($sformatf("rnd%0d_lat", t), 64'(lat), 64'(LATENCY));
            check($sformatf("rnd%0d_cep", t), 64'(cep_cnt), 64'(rlen));
        end

        // Termination after beat 2 of 4.
        cmd_valid = 1'b1; cmd_len = LEN_W'(4);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = 30'd9; op_b = 18'd9;
        @(posedge clk); #1;
        op_a = 30'd5;
        @(posedge clk); #1;
        op_valid = 1'b0;
`ifdef DSP_MAC_ABORT_EN
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_rstp", {63'd0, dsp_RSTP}, 64'd1);
        check("abort_ready", {62'd0, cmd_ready, op_ready}, 64'd2);
        @(negedge clk);
        check("abort_rstp_end", {63'd0, dsp_RSTP}, 64'd0);
`else
        RST = 1'b1;
        @(negedge clk);
        check("midrst_rstp", {63'd0, dsp_RSTP}, 64'd1);
        @(posedge clk); #1;
        RST = 1'b0;
        @(negedge clk);
        check("midrst_ready", {62'd0, cmd_ready, op_ready}, 64'd2);
        check("midrst_cep", {63'd0, dsp_CEP}, 64'd0);
        check("midrst_p", 64'(dsp_P), 64'd0);
        check("midrst_rstp_end", {63'd0, dsp_RSTP}, 64'd0);
`endif
        seen = 0;
        repeat (8) begin @(negedge clk); if (res_valid !== 1'b0) seen++; end
        check("term_no_res", 64'(seen), 64'd0);
        @(posedge clk); #1;
        va[0] = 30'd6; vb[0] = 18'd7;
        run_cmd(1, 0, 0, res, lat);
        check("post_term_sum", 64'(res), 64'd42);

        check("const_outputs", 64'(bad_const), 64'd0);
        check("opmode_legal", 64'(bad_ctl), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
